// File: rtl/serial_sub.sv
// Bit-serial subtractor D = A - B - Bin, LSB first, one full-subtractor cell plus a borrow flop.
// Optional macro SERIAL_SUB_OVF_EN enables the signed overflow flag V (otherwise V is tied to 0).
module serial_sub #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         Bin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] D,
    output logic         Bout,
    output logic         V
);

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_nx_s;
    logic [W-1:0]  a_sr_r;
    logic [W-1:0]  b_sr_r;
    logic [W-1:0]  d_sr_r;
    logic          br_r;
    logic [CW-1:0] cnt_r;
    logic          accept_s;
    logic          last_s;
    logic          d_bit_s;
    logic          br_nx_s;
    logic          busy_nx_s;
    logic          done_nx_s;

    // Full-subtractor cell and control strobes
    always_comb begin
        d_bit_s  = a_sr_r[0] ^ b_sr_r[0] ^ br_r;
        br_nx_s  = (~a_sr_r[0] & b_sr_r[0]) | (~(a_sr_r[0] ^ b_sr_r[0]) & br_r);
        accept_s = (state_r == IDLE) && start;
        last_s   = (state_r == RUN) && (cnt_r == LAST);
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nx_s = RUN;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = RUN;
                end
            end
            DONE:    state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // FSM outputs, computed from the next state so the registered flags line up with it
    always_comb begin
        busy_nx_s = (state_nx_s != IDLE);
        done_nx_s = (state_nx_s == DONE);
    end

    // Registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= busy_nx_s;
            done <= done_nx_s;
        end
    end

    // Operand/result shift registers, borrow flop and bit counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr_r <= '0;
            b_sr_r <= '0;
            d_sr_r <= '0;
            br_r   <= 1'b0;
            cnt_r  <= '0;
        end else if (accept_s) begin
            a_sr_r <= A;
            b_sr_r <= B;
            d_sr_r <= '0;
            br_r   <= Bin;
            cnt_r  <= '0;
        end else if (state_r == RUN) begin
            a_sr_r <= {1'b0, a_sr_r[W-1:1]};
            b_sr_r <= {1'b0, b_sr_r[W-1:1]};
            d_sr_r <= {d_bit_s, d_sr_r[W-1:1]};
            br_r   <= br_nx_s;
            cnt_r  <= cnt_r + CW'(1);
        end else begin
            a_sr_r <= a_sr_r;
            b_sr_r <= b_sr_r;
            d_sr_r <= d_sr_r;
            br_r   <= br_r;
            cnt_r  <= cnt_r;
        end
    end

    // Result registers: updated only on the last bit-step, held otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            D    <= '0;
            Bout <= 1'b0;
        end else if (last_s) begin
            D    <= {d_bit_s, d_sr_r[W-1:1]};
            Bout <= br_nx_s;
        end else begin
            D    <= D;
            Bout <= Bout;
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb_r;
    logic b_msb_r;

    // Operand sign capture and overflow flag; Bin deliberately excluded from V
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb_r <= 1'b0;
            b_msb_r <= 1'b0;
            V       <= 1'b0;
        end else if (accept_s) begin
            a_msb_r <= A[W-1];
            b_msb_r <= B[W-1];
            V       <= V;
        end else if (last_s) begin
            a_msb_r <= a_msb_r;
            b_msb_r <= b_msb_r;
            V       <= (a_msb_r ^ b_msb_r) & (a_msb_r ^ d_bit_s);
        end else begin
            a_msb_r <= a_msb_r;
            b_msb_r <= b_msb_r;
            V       <= V;
        end
    end
`else
    assign V = 1'b0;
`endif

endmodule
